mda_bus_sync: RTL and testbench
===============================

# mda_bus_sync

ISA bus front end for the MDA core. Synchronises the asynchronous ISA command strobes into the `clk` (pixel PLL) domain, decodes MDA memory and I/O cycles, latches address and write data, and presents single-cycle requests to the core. Holds `bus_rdy` (IOCHRDY) low while a memory cycle waits for a CPU slot from the video RAM arbiter, then drives `bus_dir` for reads until the strobe is released.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of each strobe synchroniser (≥2).
- `TIMEOUT_CYCLES`, 255: watchdog limit in `clk` cycles. Used only with `MDA_BUS_TIMEOUT_EN`.

Ports:
- `clk` in 1: pixel clock. This is the only clock.
- `busreset` in 1: synchronous, active-high reset.
- `bus_a` in 20: ISA address.
- `bus_ior_l`, `bus_iow_l`, `bus_memr_l`, `bus_memw_l` in 1 each: ISA strobes, active low, asynchronous.
- `bus_aen` in 1: DMA cycle flag. When high, the cycle is ignored.
- `bus_din` in 8: ISA data in.
- `cpu_slot` in 1: one-cycle pulse from the RAM arbiter granting the CPU access.
- `rd_data` in 8: read data from the core, valid on the cycle `cpu_slot` or `io_req` is accepted.
- `mem_req`, `io_req` out 1: one-cycle request pulses.
- `req_wr` out 1: the request is a write.
- `req_addr` out 15: latched `bus_a[14:0]`; bits [14:12] are ignored by the core.
- `req_data` out 8: latched write data.
- `bus_out` out 8: read data held for the ISA bus.
- `bus_dir` out 1: card drives `bus_d`.
- `bus_rdy` out 1: IOCHRDY, low means wait.

## Operation
- Each strobe passes through a `SYNC_STAGES` synchroniser. A cycle starts on a synchronised falling edge of one strobe.
- Decode, qualified by `bus_aen`=0:
  - Memory: `bus_a[19:15]`=5'b10110, i.e. B0000–B7FFF.
  - I/O: `bus_a[15:4]`=12'h03B, i.e. 3B0–3BF.
  - Any other cycle is ignored and leaves `bus_rdy`=1.
- Address and data are latched on the cycle the edge is detected.
- FSM states:
  - **IDLE**: memory hit goes to MWAIT, asserting `bus_rdy`=0 in the same cycle. I/O hit pulses `io_req` and goes to HOLD.
  - **MWAIT**: when `cpu_slot`=1, pulse `mem_req`, capture `rd_data` into `bus_out` if this is a read, set `bus_rdy`=1, go to HOLD.
  - **HOLD**: `bus_dir`=1 for reads. When the synchronised strobe goes high, set `bus_dir`=0 and go to IDLE.
- `bus_dir` is never asserted for writes or for decode misses.
- If two strobes fall in the same cycle (illegal on ISA), priority is memr > memw > ior > iow. The losing strobes are ignored until IDLE is re-entered.
- A strobe released during MWAIT (CPU violated IOCHRDY) aborts to IDLE with no request issued and `bus_rdy`=1.
- `busreset` mid-cycle forces IDLE immediately and applies the reset values below.

## Timing
- Reset values: `mem_req`=0, `io_req`=0, `req_wr`=0, `req_addr`=0, `req_data`=0, `bus_out`=0, `bus_dir`=0, `bus_rdy`=1. Synchroniser flops reset to 1 (inactive).
- Edge detect fires `SYNC_STAGES`+1 `clk` cycles after the raw strobe falls.
- `bus_rdy` goes low in the registered output of the detect cycle.
- `mem_req` is registered and asserts the cycle after `cpu_slot`. `bus_rdy` rises in that same cycle.
- `io_req` asserts the cycle after the edge is detected. `bus_out` for I/O reads is captured from `rd_data` on that `io_req` cycle.
- `bus_dir` falls one cycle after the synchronised strobe rises.
- Exactly one request pulse is issued per ISA cycle.

## Configuration
- `MDA_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in MWAIT.
  - When it reaches `TIMEOUT_CYCLES`, the FSM forces `bus_rdy`=1, drives `bus_out`=8'hFF for reads, issues no `mem_req`, and goes to HOLD.
- Undefined: MWAIT waits indefinitely for `cpu_slot`, and no counter logic is synthesised.

## Structure
- Shared package `mda_pkg` holds:
  - FSM state encoding: IDLE, MWAIT, HOLD.
  - `MDA_MEM_BASE`=5'b10110.
  - `MDA_IO_BASE`=12'h03B.
- One sub-module, `mda_sync_edge`: a parameterised synchroniser plus falling-edge detector, instantiated once per strobe.

## Test plan
- Memory write to B0123 with data 8'h5A, `cpu_slot` 10 cycles later:
  - `bus_rdy` is low for ≥10 cycles.
  - A single `mem_req` with `req_wr`=1, `req_addr`=15'h0123, `req_data`=8'h5A.
  - `bus_dir` stays 0.
- Memory read from B7FFF, `rd_data`=8'hC3 on the slot:
  - `bus_out`=8'hC3.
  - `bus_dir`=1 until the strobe rises, then 0 one cycle after the synchronised release.
- I/O write to 3B4 with 8'h0E:
  - `io_req` pulses with `req_addr[3:0]`=4.
  - `bus_rdy` stays 1 throughout.
- Decode misses: memory read at B8000, I/O read at 3D4, and an access with `bus_aen`=1 at B0000:
  - No request, `bus_rdy`=1, `bus_dir`=0.
- `busreset` asserted during MWAIT: all outputs take their reset values the next cycle. A following memory read completes normally.
- With `MDA_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, memory read with no `cpu_slot`:
  - `bus_rdy` rises after 16 cycles.
  - `bus_out`=8'hFF.
  - No `mem_req`.

Source files
------------

// File: rtl/mda_pkg.sv
// Shared definitions for the MDA ISA bus front end: FSM states, strobe identifiers
// and the decode bases for the MDA memory window and I/O block.
package mda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MWAIT = 2'd1,
        ST_HOLD  = 2'd2
    } bus_state_t;

    // Strobe index order doubles as the priority order for simultaneous falls.
    typedef enum logic [1:0] {
        SRC_MEMR = 2'd0,
        SRC_MEMW = 2'd1,
        SRC_IOR  = 2'd2,
        SRC_IOW  = 2'd3
    } strobe_t;

    localparam logic [4:0]  MDA_MEM_BASE = 5'b10110;
    localparam logic [11:0] MDA_IO_BASE  = 12'h03B;

    function automatic strobe_t pick_strobe(input logic [3:0] falls);
        if (falls[0]) return SRC_MEMR;
        if (falls[1]) return SRC_MEMW;
        if (falls[2]) return SRC_IOR;
        return SRC_IOW;
    endfunction

endpackage

// File: rtl/mda_sync_edge.sv
// Multi-flop synchroniser for one active-low ISA strobe, with a registered
// falling-edge pulse and the synchronised level.
module mda_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_l,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_l};
            prev_q <= sync_q[STAGES-1];
            fall   <= prev_q & ~sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];

endmodule

// File: rtl/mda_bus_sync.sv
// ISA bus front end for the MDA core: strobe synchronisation, decode, IOCHRDY wait
// and read-data hold. Optional MWAIT watchdog enabled by defining MDA_BUS_TIMEOUT_EN.
module mda_bus_sync
    import mda_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        busreset,
    input  logic [19:0] bus_a,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic [7:0]  bus_din,
    input  logic        cpu_slot,
    input  logic [7:0]  rd_data,
    output logic        mem_req,
    output logic        io_req,
    output logic        req_wr,
    output logic [14:0] req_addr,
    output logic [7:0]  req_data,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy
);

    // mem_req/io_req are one-cycle valid pulses with no ready: the core must accept
    // them on the pulse cycle, and rd_data must be valid on cpu_slot / io_req.
    logic [3:0] strobe_l;
    logic [3:0] levels;
    logic [3:0] falls;

    assign strobe_l = {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        mda_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (busreset),
            .strobe_l (strobe_l[i]),
            .level    (levels[i]),
            .fall     (falls[i])
        );
    end

    bus_state_t state_q, state_d;
    strobe_t    src_q, src_d, sel;
    logic       sel_mem, sel_wr, hit_mem, hit_io, cur_level, tmo_hit;
    logic       mem_req_d, io_req_d, req_wr_d, bus_dir_d, bus_rdy_d;
    logic [14:0] req_addr_d;
    logic [7:0]  req_data_d, bus_out_d;

    assign sel       = pick_strobe(falls);
    assign sel_mem   = (sel == SRC_MEMR) || (sel == SRC_MEMW);
    assign sel_wr    = (sel == SRC_MEMW) || (sel == SRC_IOW);
    assign hit_mem   = (|falls) && !bus_aen && sel_mem && (bus_a[19:15] == MDA_MEM_BASE);
    assign hit_io    = (|falls) && !bus_aen && !sel_mem && (bus_a[15:4] == MDA_IO_BASE);
    assign cur_level = levels[src_q];

`ifdef MDA_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;

    always_ff @(posedge clk) begin
        if (busreset || state_q != ST_MWAIT) tmo_q <= '0;
        else                                  tmo_q <= tmo_q + 8'd1;
    end

    assign tmo_hit = (state_q == ST_MWAIT) && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        mem_req_d  = 1'b0;
        io_req_d   = 1'b0;
        req_wr_d   = req_wr;
        req_addr_d = req_addr;
        req_data_d = req_data;
        bus_out_d  = bus_out;
        bus_dir_d  = bus_dir;
        bus_rdy_d  = bus_rdy;
        case (state_q)
            ST_IDLE: begin
                if (hit_mem || hit_io) begin
                    src_d      = sel;
                    req_wr_d   = sel_wr;
                    req_addr_d = bus_a[14:0];
                    req_data_d = bus_din;
                    if (hit_mem) begin
                        bus_rdy_d = 1'b0;
                        state_d   = ST_MWAIT;
                    end else begin
                        io_req_d = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_MWAIT: begin
                // A strobe released while IOCHRDY is low aborts without a request.
                if (cur_level) begin
                    bus_rdy_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cpu_slot) begin
                    mem_req_d = 1'b1;
                    bus_rdy_d = 1'b1;
                    if (!req_wr) bus_out_d = rd_data;
                    state_d = ST_HOLD;
                end else if (tmo_hit) begin
                    bus_rdy_d = 1'b1;
                    if (!req_wr) bus_out_d = 8'hFF;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (io_req && !req_wr) bus_out_d = rd_data;
                if (cur_level) begin
                    bus_dir_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    bus_dir_d = !req_wr;
                end
            end
            default: begin
                bus_dir_d = 1'b0;
                bus_rdy_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (busreset) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_MEMR;
            mem_req  <= 1'b0;
            io_req   <= 1'b0;
            req_wr   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            bus_out  <= '0;
            bus_dir  <= 1'b0;
            bus_rdy  <= 1'b1;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            mem_req  <= mem_req_d;
            io_req   <= io_req_d;
            req_wr   <= req_wr_d;
            req_addr <= req_addr_d;
            req_data <= req_data_d;
            bus_out  <= bus_out_d;
            bus_dir  <= bus_dir_d;
            bus_rdy  <= bus_rdy_d;
        end
    end

endmodule

// File: tb/tb_mda_bus_sync.sv
// Self-checking bench for mda_bus_sync: directed vector table, hand-written corner
// sequences and randomized ISA cycles checked against an address-range model.
module tb_mda_bus_sync;

    localparam int SYNC_STAGES = 2;
`ifdef MDA_BUS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic        clk;
    logic        busreset;
    logic [19:0] bus_a;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic        bus_aen;
    logic [7:0]  bus_din;
    logic        cpu_slot;
    logic [7:0]  rd_data;
    logic        mem_req, io_req, req_wr;
    logic [14:0] req_addr;
    logic [7:0]  req_data, bus_out;
    logic        bus_dir, bus_rdy;

    mda_bus_sync #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .busreset   (busreset),
        .bus_a      (bus_a),
        .bus_ior_l  (bus_ior_l),
        .bus_iow_l  (bus_iow_l),
        .bus_memr_l (bus_memr_l),
        .bus_memw_l (bus_memw_l),
        .bus_aen    (bus_aen),
        .bus_din    (bus_din),
        .cpu_slot   (cpu_slot),
        .rd_data    (rd_data),
        .mem_req    (mem_req),
        .io_req     (io_req),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .bus_out    (bus_out),
        .bus_dir    (bus_dir),
        .bus_rdy    (bus_rdy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: counts pulses and wait/drive cycles per ISA transaction
    int          mem_cnt, io_cnt, rdy_low_cnt, dir_cnt;
    logic        last_wr;
    logic [14:0] last_addr;
    logic [7:0]  last_data;

    always @(negedge clk) begin
        if (!busreset) begin
            if (mem_req || io_req) begin
                last_wr   = req_wr;
                last_addr = req_addr;
                last_data = req_data;
            end
            if (mem_req) mem_cnt++;
            if (io_req) io_cnt++;
            if (!bus_rdy) rdy_low_cnt++;
            if (bus_dir) dir_cnt++;
        end
    end

    // reference model: 0 = ignored, 1 = memory hit, 2 = I/O hit
    function automatic int model_hit(input int kind, input logic [19:0] a, input logic aen);
        int ai;
        ai = int'(a);
        if (aen) return 0;
        if (kind < 2) return (ai >= 'hB0000 && ai < 'hB8000) ? 1 : 0;
        return (((ai % 65536) / 16) == 'h3B) ? 2 : 0;
    endfunction

    // driver tasks
    task automatic set_strobe(input int kind, input logic val);
        case (kind)
            0: bus_memr_l = val;
            1: bus_memw_l = val;
            2: bus_ior_l  = val;
            default: bus_iow_l = val;
        endcase
    endtask

    typedef struct {
        int          kind;
        logic [19:0] addr;
        logic [7:0]  din;
        logic        aen;
        int          slot_dly;
        logic [7:0]  rdv;
        int          exp_hit;
    } vec_t;

    task automatic clear_mon();
        mem_cnt = 0; io_cnt = 0; rdy_low_cnt = 0; dir_cnt = 0;
    endtask

    task automatic do_cycle(input vec_t v, input int exp_hit);
        int n;
        bit rd;
        rd = (v.kind == 0) || (v.kind == 2);
        clear_mon();
        bus_a = v.addr; bus_din = v.din; bus_aen = v.aen;
        rd_data = (exp_hit == 2) ? v.rdv : ~v.rdv;
        @(negedge clk);
        set_strobe(v.kind, 1'b0);
        if (exp_hit == 1) begin
            n = 0;
            while (bus_rdy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
            check("rdy_fall_latency", n, SYNC_STAGES + 2);
            repeat (v.slot_dly) @(negedge clk);
            check("mem_req_before_slot", mem_cnt, 0);
            cpu_slot = 1'b1; rd_data = v.rdv;
            @(negedge clk);
            cpu_slot = 1'b0; rd_data = 8'($urandom);
            check("mem_req_after_slot", mem_req, 1);
            check("rdy_high_with_req", bus_rdy, 1);
            check("rdy_low_cycles", rdy_low_cnt >= v.slot_dly, 1);
        end else if (exp_hit == 2) begin
            n = 0;
            while (io_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            check("io_req_latency", n, SYNC_STAGES + 2);
        end else begin
            repeat (SYNC_STAGES + 6) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("bus_dir_hold", bus_dir, (exp_hit != 0) && rd);
        set_strobe(v.kind, 1'b1);
        n = 0;
        while (bus_dir !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        if (exp_hit != 0 && rd) check("dir_fall_latency", n, SYNC_STAGES + 1);
        repeat (4) @(negedge clk);
        check("mem_req_count", mem_cnt, (exp_hit == 1) ? 1 : 0);
        check("io_req_count", io_cnt, (exp_hit == 2) ? 1 : 0);
        check("rdy_idle", bus_rdy, 1);
        if (exp_hit != 0) begin
            check("req_wr", last_wr, !rd);
            check("req_addr", last_addr, int'(v.addr) % 32768);
            if (!rd) check("req_data", last_data, v.din);
            else     check("bus_out", bus_out, v.rdv);
        end
        if (exp_hit != 1) check("rdy_never_low", rdy_low_cnt, 0);
        if (exp_hit == 0 || !rd) check("dir_never_high", dir_cnt, 0);
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        busreset = 1'b1;
        bus_a = '0; bus_din = '0; bus_aen = 1'b0;
        bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        cpu_slot = 1'b0; rd_data = '0;
        repeat (3) @(negedge clk);
        check("reset_rdy", bus_rdy, 1);
        check("reset_dir", bus_dir, 0);
        check("reset_reqs", {mem_req, io_req, req_wr}, 0);
        busreset = 1'b0;
        repeat (4) @(negedge clk);

        //          kind addr        din    aen   slot rdv    exp
        vecs[0] = '{1, 20'hB0123, 8'h5A, 1'b0, 10, 8'h00, 1};
        vecs[1] = '{0, 20'hB7FFF, 8'h00, 1'b0, 3,  8'hC3, 1};
        vecs[2] = '{3, 20'h003B4, 8'h0E, 1'b0, 0,  8'h00, 2};
        vecs[3] = '{0, 20'hB8000, 8'h00, 1'b0, 0,  8'h11, 0};
        vecs[4] = '{2, 20'h003D4, 8'h00, 1'b0, 0,  8'h22, 0};
        vecs[5] = '{1, 20'hB0000, 8'h77, 1'b1, 0,  8'h00, 0};
        vecs[6] = '{2, 20'h003BF, 8'h00, 1'b0, 0,  8'hA5, 2};
        vecs[7] = '{1, 20'hB0000, 8'h81, 1'b0, 0,  8'h00, 1};
        vecs[8] = '{0, 20'h003B0, 8'h00, 1'b0, 0,  8'h33, 0};
        for (int i = 0; i < 9; i++) do_cycle(vecs[i], vecs[i].exp_hit);

        // reset in MWAIT, then a normal read
        clear_mon();
        bus_a = 20'hB0010; bus_aen = 1'b0;
        bus_memr_l = 1'b0;
        for (int n = 0; n < 20 && bus_rdy !== 1'b0; n++) @(negedge clk);
        check("mwait_before_reset", bus_rdy, 0);
        busreset = 1'b1; bus_memr_l = 1'b1;
        @(negedge clk);
        check("rst_rdy", bus_rdy, 1);
        check("rst_pulses", {mem_req, io_req}, 0);
        check("rst_req_wr", req_wr, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_data", req_data, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_bus_dir", bus_dir, 0);
        busreset = 1'b0;
        repeat (5) @(negedge clk);
        rv = '{0, 20'hB4321, 8'h00, 1'b0, 2, 8'h6D, 1};
        do_cycle(rv, 1);

        // strobe released during MWAIT aborts without a request
        clear_mon();
        bus_a = 20'hB0200; bus_memr_l = 1'b0;
        for (int n = 0; n < 20 && bus_rdy !== 1'b0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        bus_memr_l = 1'b1;
        for (int n = 0; n < 10 && bus_rdy !== 1'b1; n++) @(negedge clk);
        check("abort_rdy", bus_rdy, 1);
        repeat (3) @(negedge clk);
        cpu_slot = 1'b1; @(negedge clk); cpu_slot = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_req", mem_cnt + io_cnt, 0);
        check("abort_no_dir", dir_cnt, 0);

        // memw and ior fall together at an I/O address: memw wins and misses
        clear_mon();
        bus_a = 20'h003B0; @(negedge clk);
        bus_memw_l = 1'b0; bus_ior_l = 1'b0;
        repeat (10) @(negedge clk);
        bus_memw_l = 1'b1; bus_ior_l = 1'b1;
        repeat (6) @(negedge clk);
        check("prio_no_req", mem_cnt + io_cnt, 0);
        check("prio_rdy", rdy_low_cnt, 0);

`ifdef MDA_BUS_TIMEOUT_EN
        // no cpu_slot: watchdog releases the wait and returns 8'hFF
        clear_mon();
        bus_a = 20'hB0100; rd_data = 8'h12; @(negedge clk);
        bus_memr_l = 1'b0;
        for (int n = 0; n < 20 && bus_rdy !== 1'b0; n++) @(negedge clk);
        for (int n = 0; n < 40 && bus_rdy !== 1'b1; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("tmo_rdy_low_cycles", rdy_low_cnt, TMO);
        check("tmo_bus_out", bus_out, 8'hFF);
        check("tmo_no_mem_req", mem_cnt, 0);
        bus_memr_l = 1'b1;
        repeat (8) @(negedge clk);
`endif

        // randomized cycles against the address-range model
        for (int i = 0; i < 24; i++) begin
            int r;
            rv.kind = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 3));
            case (r)
                0: rv.addr = 20'hB0000 + 20'($urandom_range(0, 'h7FFF));
                1: rv.addr = 20'(($urandom_range(0, 15) << 16) | 'h3B0 | $urandom_range(0, 15));
                2: rv.addr = 20'($urandom);
                default: rv.addr = ($urandom_range(0, 1) != 0) ? 20'hB8000 + 20'($urandom_range(0, 255))
                                                                 : 20'hAFF00 + 20'($urandom_range(0, 255));
            endcase
            rv.din = 8'($urandom);
            rv.aen = ($urandom_range(0, 7) == 0);
            rv.slot_dly = int'($urandom_range(0, 12));
            rv.rdv = 8'($urandom);
            rv.exp_hit = model_hit(rv.kind, rv.addr, rv.aen);
            do_cycle(rv, rv.exp_hit);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
